// File: rtl/tt_pkg.sv
// Shared constants and types for the truth-table capture block.
//   N_IN  : number of inputs of the function under test
//   TT_W  : truth-table width (2**N_IN)
//   WT_W  : onset-weight width (N_IN+1, holds 0..TT_W)
package tt_pkg;

  localparam int unsigned N_IN = 7;
  localparam int unsigned TT_W = 2 ** N_IN;
  localparam int unsigned WT_W = N_IN + 1;

  typedef logic [TT_W-1:0] tt_t;
  typedef logic [N_IN-1:0] vec_t;
  typedef logic [WT_W-1:0] wt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Last input vector of a sweep.
  localparam vec_t X_LAST = vec_t'(TT_W - 1);

endpackage

// File: rtl/tt_capture_if.sv
// Capture request/result bundle between a controller and tt_capture.
//   start, exp_tt        : capture request and expected table
//   x_out, f_in          : vector to / output from the function under test
//   busy, done, tt_valid : capture status
//   tt_out, weight, match: captured table, its popcount, compare result
interface tt_capture_if;

  logic          start;
  tt_pkg::tt_t   exp_tt;
  tt_pkg::vec_t  x_out;
  logic          f_in;
  logic          busy;
  logic          done;
  logic          tt_valid;
  tt_pkg::tt_t   tt_out;
  tt_pkg::wt_t   weight;
  logic          match;

  modport master (
    output start, exp_tt, f_in,
    input  x_out, busy, done, tt_valid, tt_out, weight, match
  );

  modport slave (
    input  start, exp_tt, f_in,
    output x_out, busy, done, tt_valid, tt_out, weight, match
  );

endinterface

// File: rtl/tt_hold_timer.sv
// LAT-cycle wait counter used while a vector settles through a pipelined
// function under test.
//   clk, rst_n : clock, async active-low reset
//   run        : counter advances while high, clears while low
//   term_c     : combinational, high on the last wait cycle (count == LAT-1)
module tt_hold_timer #(
  parameter int unsigned LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic term_c
);

  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

  logic [CW-1:0] cnt;

  assign term_c = run && (cnt == CW'(LAT - 1));

  // Count 0..LAT-1, restart from 0 after terminal or when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || term_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tt_capture.sv
// Sequential truth-table extractor: sweeps x_out over 0..TT_W-1, samples
// f_in after LAT settle cycles per vector, builds tt_out (bit i = f(i)),
// its onset weight, and a compare against a latched expected table.
//   clk, rst_n : clock, async active-low reset
//   cap        : tt_capture_if slave (start/exp_tt/f_in in, results out)
module tt_capture
  import tt_pkg::*;
#(
  parameter int unsigned LAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  tt_capture_if.slave  cap
);

  localparam bit     HAS_HOLD   = (LAT != 0);
  localparam state_t AFTER_VEC  = HAS_HOLD ? HOLD : SAMPLE;

  state_t state, state_nx;
  logic   hold_term_c;
  logic   last_c;

  vec_t   x_q;
  tt_t    tt_q;
  tt_t    exp_q;
  wt_t    wt_q;
  logic   busy_q;
  logic   done_q;
  logic   valid_q;

  assign last_c = (x_q == X_LAST);

  // Settle timer only exists for pipelined functions under test.
  generate
    if (HAS_HOLD) begin : g_hold
      tt_hold_timer #(.LAT(LAT)) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (state == HOLD),
        .term_c (hold_term_c)
      );
    end else begin : g_no_hold
      assign hold_term_c = 1'b0;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (cap.start) state_nx = AFTER_VEC;
      HOLD:       if (hold_term_c) state_nx = SAMPLE;
      SAMPLE:     state_nx = last_c ? DONE : AFTER_VEC;
      default:    state_nx = IDLE;
    endcase
  end

  // Registered datapath and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      tt_q    <= '0;
      exp_q   <= '0;
      wt_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (cap.start) begin
            exp_q   <= cap.exp_tt;
            tt_q    <= '0;
            wt_q    <= '0;
            x_q     <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        SAMPLE: begin
          tt_q[x_q] <= cap.f_in;
          wt_q      <= wt_q + wt_t'(cap.f_in);
          if (last_c) begin
            // x_out parks on the last vector until the next start.
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            x_q <= x_q + vec_t'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cap.x_out    = x_q;
  assign cap.tt_out   = tt_q;
  assign cap.weight   = wt_q;
  assign cap.busy     = busy_q;
  assign cap.done     = done_q;
  assign cap.tt_valid = valid_q;
  assign cap.match    = valid_q && (tt_q == exp_q);

endmodule

// File: tb/tb_tt_capture.sv
// Self-checking bench for tt_capture: one LAT=0 and one LAT=2 instance,
// directed and random functions checked against a table model.
module tb_tt_capture;
  import tt_pkg::*;

  localparam tt_t MAJ_TT = 128'hfeeeeee8eee8e8a0fae8e888e8888880;
  localparam tt_t X0_TT  = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
  localparam int  LIMIT  = 2000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tt_capture_if bus0 ();
  tt_capture_if bus2 ();

  tt_capture #(.LAT(0)) u0 (.clk(clk), .rst_n(rst_n), .cap(bus0));
  tt_capture #(.LAT(2)) u2 (.clk(clk), .rst_n(rst_n), .cap(bus2));

  // Functions under test: LAT=0 combinational, LAT=2 behind two registers.
  bit  use_x0;
  tt_t ftab0;
  tt_t ftab2;
  logic p1, p2;

  assign bus0.f_in = use_x0 ? bus0.x_out[0] : ftab0[bus0.x_out];

  always_ff @(posedge clk) begin
    p1 <= ftab2[bus2.x_out];
    p2 <= p1;
  end
  assign bus2.f_in = p2;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  // Reference: the table a full sweep must produce.
  function automatic tt_t model_tt(input bit x0_mode, input tt_t tab);
    tt_t r;
    for (int i = 0; i < 128; i++) r[i] = x0_mode ? (i % 2 == 1) : tab[i];
    return r;
  endfunction

  function automatic tt_t rand_tt();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start0(input tt_t e);
    bus0.exp_tt = e;
    bus0.start  = 1'b1;
    @(negedge clk);
    bus0.start  = 1'b0;
  endtask

  task automatic start2(input tt_t e);
    bus2.exp_tt = e;
    bus2.start  = 1'b1;
    @(negedge clk);
    bus2.start  = 1'b0;
  endtask

  // Wait for done, counting cycles from accept; optional stray starts and abort.
  task automatic run0(input int pa, input int pb, input int abort_at,
                      output int cyc, output int xbad);
    cyc = 0;
    xbad = 0;
    while (bus0.done !== 1'b1 && cyc < LIMIT && cyc != abort_at) begin
      if (bus0.x_out !== 7'((cyc > 127) ? 127 : cyc)) xbad++;
      bus0.start = (cyc == pa || cyc == pb);
      @(negedge clk);
      cyc++;
    end
    bus0.start = 1'b0;
  endtask

  task automatic run2(output int cyc, output int xbad);
    cyc = 0;
    xbad = 0;
    while (bus2.done !== 1'b1 && cyc < LIMIT) begin
      if (bus2.x_out !== 7'((cyc / 3 > 127) ? 127 : cyc / 3)) xbad++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic finish0(input string tag, input int cyc, input int xbad,
                         input tt_t tt_exp, input tt_t exp_in);
    chk({tag, "_cycles"}, 128'(cyc), 128'd128);
    chk({tag, "_xseq"}, 128'(xbad), 128'd0);
    chk({tag, "_done"}, 128'(bus0.done), 128'd1);
    chk({tag, "_busy"}, 128'(bus0.busy), 128'd0);
    chk({tag, "_valid"}, 128'(bus0.tt_valid), 128'd1);
    chk({tag, "_x_last"}, 128'(bus0.x_out), 128'd127);
    chk({tag, "_tt"}, bus0.tt_out, tt_exp);
    chk({tag, "_weight"}, 128'(bus0.weight), 128'($countones(tt_exp)));
    chk({tag, "_match"}, 128'(bus0.match), 128'(tt_exp == exp_in));
  endtask

  initial begin
    int  cyc, xbad;
    tt_t t, e;

    rst_n = 1'b0;
    use_x0 = 1'b0;
    ftab0 = '0;
    ftab2 = '0;
    bus0.start = 1'b0;
    bus0.exp_tt = '0;
    bus2.start = 1'b0;
    bus2.exp_tt = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_x", 128'(bus0.x_out), 128'd0);
    chk("rst_tt", bus0.tt_out, 128'd0);
    chk("rst_weight", 128'(bus0.weight), 128'd0);
    chk("rst_status", 128'({bus0.busy, bus0.done, bus0.tt_valid, bus0.match}), 128'd0);
    chk("rst2_status", 128'({bus2.busy, bus2.done, bus2.tt_valid, bus2.match, bus2.x_out}), 128'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_status", 128'({bus0.busy, bus0.done, bus0.tt_valid}), 128'd0);

    // f = x0.
    use_x0 = 1'b1;
    start0('0);
    chk("x0_busy_at_accept", 128'(bus0.busy), 128'd1);
    run0(-1, -1, -1, cyc, xbad);
    finish0("x0", cyc, xbad, X0_TT, '0);
    chk("x0_literal", bus0.tt_out, X0_TT);
    @(negedge clk);
    chk("x0_done_pulse", 128'(bus0.done), 128'd0);
    chk("x0_valid_hold", 128'(bus0.tt_valid), 128'd1);
    chk("x0_x_hold", 128'(bus0.x_out), 128'd127);

    // Majority-network table, exact and with one expected bit flipped.
    use_x0 = 1'b0;
    ftab0 = MAJ_TT;
    start0(MAJ_TT);
    run0(-1, -1, -1, cyc, xbad);
    finish0("maj", cyc, xbad, model_tt(1'b0, ftab0), MAJ_TT);
    chk("maj_match1", 128'(bus0.match), 128'd1);
    e = MAJ_TT ^ (128'd1 << $urandom_range(127, 0));
    start0(e);
    run0(-1, -1, -1, cyc, xbad);
    finish0("maj_flip", cyc, xbad, model_tt(1'b0, ftab0), e);
    chk("maj_match0", 128'(bus0.match), 128'd0);

    // Stray starts while busy are ignored.
    ftab0 = rand_tt();
    start0(ftab0);
    run0(10, 60, -1, cyc, xbad);
    finish0("stray", cyc, xbad, model_tt(1'b0, ftab0), ftab0);

    // Reset mid-capture, then a clean capture.
    ftab0 = rand_tt();
    start0(ftab0);
    run0(-1, -1, 50, cyc, xbad);
    chk("abort_xseq", 128'(xbad), 128'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_x", 128'(bus0.x_out), 128'd0);
    chk("abort_weight", 128'(bus0.weight), 128'd0);
    chk("abort_tt", bus0.tt_out, 128'd0);
    chk("abort_status", 128'({bus0.busy, bus0.tt_valid, bus0.match}), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start0(ftab0);
    run0(-1, -1, -1, cyc, xbad);
    finish0("post_rst", cyc, xbad, model_tt(1'b0, ftab0), ftab0);

    // Constant 0, then restart on the first DONE cycle.
    ftab0 = '0;
    start0('0);
    run0(-1, -1, -1, cyc, xbad);
    finish0("zero", cyc, xbad, '0, '0);
    ftab0 = rand_tt();
    start0(ftab0);
    chk("restart_valid", 128'(bus0.tt_valid), 128'd0);
    chk("restart_busy", 128'(bus0.busy), 128'd1);
    chk("restart_match", 128'(bus0.match), 128'd0);
    chk("restart_x", 128'(bus0.x_out), 128'd0);
    chk("restart_weight", 128'(bus0.weight), 128'd0);
    run0(-1, -1, -1, cyc, xbad);
    finish0("restart", cyc, xbad, model_tt(1'b0, ftab0), ftab0);

    // Random tables, expected table equal or perturbed.
    for (int n = 0; n < 3; n++) begin
      ftab0 = rand_tt();
      e = ($urandom_range(1, 0) == 1) ? ftab0 : (ftab0 ^ (128'd1 << $urandom_range(127, 0)));
      start0(e);
      run0(-1, -1, -1, cyc, xbad);
      finish0("rand", cyc, xbad, model_tt(1'b0, ftab0), e);
    end

    // LAT=2: constant 1 through a two-stage pipeline, then a random table.
    ftab2 = '1;
    repeat (3) @(negedge clk);
    start2('1);
    run2(cyc, xbad);
    chk("lat2_cycles", 128'(cyc), 128'd384);
    chk("lat2_hold3", 128'(xbad), 128'd0);
    chk("lat2_tt", bus2.tt_out, model_tt(1'b0, ftab2));
    chk("lat2_weight", 128'(bus2.weight), 128'd128);
    chk("lat2_status", 128'({bus2.done, bus2.busy, bus2.tt_valid, bus2.match}), 128'b1011);

    ftab2 = rand_tt();
    t = rand_tt();
    repeat (3) @(negedge clk);
    start2(t);
    run2(cyc, xbad);
    chk("lat2r_cycles", 128'(cyc), 128'd384);
    chk("lat2r_hold3", 128'(xbad), 128'd0);
    chk("lat2r_tt", bus2.tt_out, model_tt(1'b0, ftab2));
    chk("lat2r_weight", 128'(bus2.weight), 128'($countones(ftab2)));
    chk("lat2r_match", 128'(bus2.match), 128'(ftab2 == t));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
